// File: rtl/snn_wb_master.sv
// Wishbone classic initiator running one SNN inference step: write 8 spike words, trigger calc, read 8 result words.
// Optional SNN_WBM_TIMEOUT_EN adds a per-transfer ack timeout that aborts the step with err_o.
module snn_wb_master (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         start_i,
    input  logic         core_sel_i,
    input  logic [255:0] spike_vec_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o,
    output logic [255:0] spike_out_o,
    output logic         wbm_cyc_o,
    output logic         wbm_stb_o,
    output logic         wbm_we_o,
    output logic [3:0]   wbm_sel_o,
    output logic [31:0]  wbm_adr_o,
    output logic [31:0]  wbm_dat_o,
    input  logic         wbm_ack_i,
    input  logic [31:0]  wbm_dat_i
);
    localparam logic [31:0] IMEM_BASE_0 = 32'h8000_0000;
    localparam logic [31:0] IMEM_BASE_1 = 32'h8001_0000;
    localparam logic [31:0] OMEM_BASE_0 = 32'h8004_0000;
    localparam logic [31:0] OMEM_BASE_1 = 32'h8005_0000;
    localparam logic [31:0] CALC_ADDR_0 = 32'h8003_0000;
    localparam logic [31:0] CALC_ADDR_1 = 32'h8003_0004;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_SPK, S_WR_CALC, S_RD_OUT, S_GAP, S_DONE
    } state_t;

    state_t         r_state, w_state_nxt, r_pend;
    logic [2:0]     r_k;
    logic           r_core;
    logic [255:0]   r_spk;
    logic [255:0]   r_shadow;
    logic [255:0]   r_spike_out;
    logic           w_xfer;
    logic           w_timeout;
    logic           w_err;
    logic [31:0]    w_offs;

    assign w_xfer = (r_state == S_WR_SPK) || (r_state == S_WR_CALC) || (r_state == S_RD_OUT);
    assign w_offs = {27'd0, r_k, 2'b00};

`ifdef SNN_WBM_TIMEOUT_EN
    localparam logic [7:0] ACK_TIMEOUT = 8'd255;
    logic [7:0] r_to_cnt;
    logic       r_err;

    // Down-counter reloads whenever no transfer is pending; reaching zero without ack aborts.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_to_cnt <= ACK_TIMEOUT - 8'd1;
            r_err    <= 1'b0;
        end else begin
            if (!w_xfer || wbm_ack_i) r_to_cnt <= ACK_TIMEOUT - 8'd1;
            else                      r_to_cnt <= r_to_cnt - 8'd1;
            if (r_state == S_IDLE && start_i) r_err <= 1'b0;
            else if (w_timeout)               r_err <= 1'b1;
        end
    end
    assign w_timeout = w_xfer && !wbm_ack_i && (r_to_cnt == 8'd0);
    assign w_err     = r_err;
`else
    assign w_timeout = 1'b0;
    assign w_err     = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start_i) w_state_nxt = S_WR_SPK;
            S_WR_SPK, S_WR_CALC: begin
                if (wbm_ack_i)      w_state_nxt = S_GAP;
                else if (w_timeout) w_state_nxt = S_DONE;
            end
            S_RD_OUT: begin
                if (wbm_ack_i)      w_state_nxt = (r_k == 3'd7) ? S_DONE : S_GAP;
                else if (w_timeout) w_state_nxt = S_DONE;
            end
            S_GAP:     w_state_nxt = r_pend;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from registered state only, so they are glitch-free and clear on reset.
    always_comb begin
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        wbm_we_o  = 1'b0;
        wbm_sel_o = 4'h0;
        wbm_adr_o = 32'd0;
        wbm_dat_o = 32'd0;
        busy_o    = (r_state != S_IDLE);
        done_o    = (r_state == S_DONE);
        err_o     = (r_state == S_DONE) && w_err;
        case (r_state)
            S_WR_SPK: begin
                wbm_we_o  = 1'b1;
                wbm_adr_o = (r_core ? IMEM_BASE_1 : IMEM_BASE_0) + w_offs;
                wbm_dat_o = r_spk[{r_k, 5'd0} +: 32];
            end
            S_WR_CALC: begin
                wbm_we_o  = 1'b1;
                wbm_adr_o = r_core ? CALC_ADDR_1 : CALC_ADDR_0;
                wbm_dat_o = 32'h1;
            end
            S_RD_OUT:  wbm_adr_o = (r_core ? OMEM_BASE_1 : OMEM_BASE_0) + w_offs;
            default: ;
        endcase
        if (w_xfer) begin
            wbm_cyc_o = 1'b1;
            wbm_stb_o = 1'b1;
            wbm_sel_o = 4'hF;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_pend      <= S_IDLE;
            r_k         <= 3'd0;
            r_core      <= 1'b0;
            r_spk       <= '0;
            r_shadow    <= '0;
            r_spike_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start_i) begin
                    r_spk  <= spike_vec_i;
                    r_core <= core_sel_i;
                    r_k    <= 3'd0;
                end
                S_WR_SPK: if (wbm_ack_i) begin
                    r_k    <= r_k + 3'd1;
                    r_pend <= (r_k == 3'd7) ? S_WR_CALC : S_WR_SPK;
                end
                S_WR_CALC: if (wbm_ack_i) begin
                    r_k    <= 3'd0;
                    r_pend <= S_RD_OUT;
                end
                S_RD_OUT: if (wbm_ack_i) begin
                    r_shadow[{r_k, 5'd0} +: 32] <= wbm_dat_i;
                    r_k    <= r_k + 3'd1;
                    r_pend <= S_RD_OUT;
                end
                S_DONE: if (!w_err) r_spike_out <= r_shadow;
                default: ;
            endcase
        end
    end

    assign spike_out_o = r_spike_out;
endmodule

// File: tb/tb_snn_wb_master.sv
// Directed bench for snn_wb_master with a behavioural Wishbone slave (configurable wait states).
module tb_snn_wb_master;
    logic         wb_clk_i = 1'b0;
    logic         wb_rst_i = 1'b0;
    logic         start_i = 1'b0;
    logic         core_sel_i = 1'b0;
    logic [255:0] spike_vec_i = '0;
    logic         busy_o, done_o, err_o;
    logic [255:0] spike_out_o;
    logic         wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]   wbm_sel_o;
    logic [31:0]  wbm_adr_o, wbm_dat_o;
    logic         wbm_ack_i;
    logic [31:0]  wbm_dat_i;

    int n_checks = 0;
    int n_errors = 0;

    snn_wb_master dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start_i(start_i),
        .core_sel_i(core_sel_i), .spike_vec_i(spike_vec_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .spike_out_o(spike_out_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Slave: acks after s_waits stall cycles; read data is 0x1000_0000 + word index.
    logic [7:0] s_waits = 8'd0;
    logic [7:0] s_wcnt  = 8'd0;
    logic       s_noack = 1'b0;
    assign wbm_ack_i = wbm_cyc_o & wbm_stb_o & ~s_noack & (s_wcnt == s_waits);
    assign wbm_dat_i = 32'h1000_0000 + {29'd0, wbm_adr_o[4:2]};

    always @(posedge wb_clk_i) begin
        if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) s_wcnt <= s_wcnt + 8'd1;
        else                                      s_wcnt <= 8'd0;
    end

    logic [31:0] log_adr[$];
    logic [31:0] log_dat[$];
    logic        log_we[$];
    int          stab_err = 0;
    logic        h_hold = 1'b0;
    logic [31:0] h_adr, h_dat;
    logic        h_we;

    always @(posedge wb_clk_i) begin
        if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
            log_adr.push_back(wbm_adr_o);
            log_dat.push_back(wbm_dat_o);
            log_we.push_back(wbm_we_o);
        end
        if (h_hold && wbm_stb_o && (wbm_adr_o != h_adr || wbm_dat_o != h_dat || wbm_we_o != h_we))
            stab_err <= stab_err + 1;
        if (wbm_stb_o && wbm_sel_o != 4'hF) stab_err <= stab_err + 1;
        h_hold <= wbm_stb_o && !wbm_ack_i;
        h_adr  <= wbm_adr_o;
        h_dat  <= wbm_dat_o;
        h_we   <= wbm_we_o;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] exp_result();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = 32'h1000_0000 + 32'(k);
        return v;
    endfunction

    task automatic clear_log();
        log_adr.delete();
        log_dat.delete();
        log_we.delete();
    endtask

    task automatic run_step(input logic sel, input logic [255:0] vec, input bit spam,
                            input int exp_cycles);
        int cyc;
        logic [31:0] ib, cb, ob;
        bit got;
        ib = sel ? 32'h8001_0000 : 32'h8000_0000;
        cb = sel ? 32'h8003_0004 : 32'h8003_0000;
        ob = sel ? 32'h8005_0000 : 32'h8004_0000;
        clear_log();
        @(negedge wb_clk_i);
        core_sel_i  = sel;
        spike_vec_i = vec;
        start_i     = 1'b1;
        @(posedge wb_clk_i);
        cyc = 0;
        got = 0;
        while (cyc < 3000) begin
            @(negedge wb_clk_i);
            cyc++;
            start_i     = spam && cyc >= 1 && cyc < 30;
            spike_vec_i = ~vec;
            core_sel_i  = ~sel;
            if (cyc == 1) chk("busy_rise", busy_o, 1);
            if (done_o) begin got = 1; break; end
        end
        start_i = 1'b0;
        chk("done_seen", got, 1);
        chk("done_cycle", cyc, exp_cycles);
        chk("err_on_done", err_o, 0);
        @(negedge wb_clk_i);
        chk("done_pulse_end", done_o, 0);
        chk("busy_fall", busy_o, 0);
        chk("spike_out", spike_out_o, exp_result());
        repeat (3) @(negedge wb_clk_i);
        chk("no_requeue", busy_o, 0);
        chk("xfer_count", log_adr.size(), 17);
        if (log_adr.size() == 17) begin
            for (int i = 0; i < 8; i++) begin
                chk("wr_adr", log_adr[i], ib + 32'(4*i));
                chk("wr_dat", log_dat[i], vec[32*i +: 32]);
                chk("wr_we", log_we[i], 1);
            end
            chk("calc_adr", log_adr[8], cb);
            chk("calc_dat", log_dat[8], 32'h1);
            chk("calc_we", log_we[8], 1);
            for (int i = 0; i < 8; i++) begin
                chk("rd_adr", log_adr[9+i], ob + 32'(4*i));
                chk("rd_we", log_we[9+i], 0);
            end
        end
        chk("stable_bus", stab_err, 0);
    endtask

    logic [255:0] vec_a, vec_b;
    int n;
    bit hit;

    initial begin
        for (int k = 0; k < 8; k++) begin
            vec_a[32*k +: 32] = 32'hA5A5_0000 + 32'(k);
            vec_b[32*k +: 32] = 32'h5A5A_0000 + 32'(k * 16'h0101);
        end
        #12 wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        chk("rst_cyc", wbm_cyc_o, 0);
        chk("rst_stb", wbm_stb_o, 0);
        chk("rst_sel", wbm_sel_o, 0);
        chk("rst_adr", wbm_adr_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_spike", spike_out_o, 0);

        s_waits = 8'd0;
        run_step(1'b0, vec_a, 1'b0, 34);

        s_waits = 8'd3;
        run_step(1'b1, vec_b, 1'b0, 85);

        s_waits = 8'd0;
        run_step(1'b0, vec_b, 1'b1, 34);

        clear_log();
        @(negedge wb_clk_i);
        core_sel_i = 1'b0;
        start_i    = 1'b1;
        @(posedge wb_clk_i);
        hit = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge wb_clk_i);
            start_i = 1'b0;
            if (wbm_stb_o && !wbm_we_o && wbm_adr_o == 32'h8004_0010) begin hit = 1; break; end
        end
        chk("rd4_reached", hit, 1);
        #2 wb_rst_i = 1'b0;
        #1;
        chk("mid_rst_cyc", wbm_cyc_o, 0);
        chk("mid_rst_stb", wbm_stb_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_spike", spike_out_o, 0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        chk("post_rst_idle", busy_o, 0);
        run_step(1'b0, vec_a, 1'b0, 34);

`ifdef SNN_WBM_TIMEOUT_EN
        s_noack = 1'b1;
        @(negedge wb_clk_i);
        start_i = 1'b1;
        @(posedge wb_clk_i);
        n = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge wb_clk_i);
            start_i = 1'b0;
            if (wbm_stb_o) n++;
            else if (n > 0) break;
        end
        chk("to_stb_cycles", n, 255);
        chk("to_cyc_drop", wbm_cyc_o, 0);
        chk("to_done", done_o, 1);
        chk("to_err", err_o, 1);
        s_noack = 1'b0;
        @(negedge wb_clk_i);
        chk("to_err_pulse", err_o, 0);
        chk("to_spike_kept", spike_out_o, exp_result());
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/snn_wb_master.md
# snn_wb_master

Wishbone classic initiator that drives one complete inference step on the two-core SNN slave. On a start pulse it writes a latched 256-bit axon spike vector into the selected core's IMEM as eight 32-bit words, then writes the core's calc-trigger address. It then reads the eight OMEM words back and presents the 256-bit neuron spike result. It sits between a host/sequencer and the SNN Wishbone slave port.

## Interface
- IMEM_BASE_0, 32'h80000000, core 0 input spike memory base
- IMEM_BASE_1, 32'h80010000, core 1 input spike memory base
- OMEM_BASE_0, 32'h80040000, core 0 output spike memory base
- OMEM_BASE_1, 32'h80050000, core 1 output spike memory base
- CALC_ADDR_0, 32'h80030000, core 0 calc-trigger address (write, data ignored by slave)
- CALC_ADDR_1, 32'h80030004, core 1 calc-trigger address
- ACK_TIMEOUT, 255, max cycles to wait for ack per transfer (8-bit counter)

- wb_clk_i  in  1  clock (single clock domain)
- wb_rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  one-cycle start request, sampled only in IDLE
- core_sel_i  in  1  core to run (0/1), latched at start
- spike_vec_i  in  256  axon spikes, latched at start
- busy_o  out  1  high from accepted start until return to IDLE
- done_o  out  1  one-cycle pulse at end of step (success or error)
- err_o  out  1  one-cycle pulse with done_o on timeout abort
- spike_out_o  out  256  last successfully read neuron spikes
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone control
- wbm_sel_o  out  4  always 4'hF during a transfer, 4'h0 otherwise
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_ack_i  in  1  slave acknowledge
- wbm_dat_i  in  32  read data

## Operation
- States: IDLE, WR_SPK, WR_CALC, RD_OUT, GAP, DONE.
- IDLE: on start_i=1, latch spike_vec_i, core_sel_i; word index k=0; go WR_SPK.
- WR_SPK: cyc=stb=we=1, adr=IMEM_BASE_sel+4k, dat=spike_vec[32k+31:32k]. On ack: k++, go GAP; after k=7 ack, next is WR_CALC.
- WR_CALC: cyc=stb=we=1, adr=CALC_ADDR_sel, dat=32'h1. On ack go GAP, next RD_OUT with k=0.
- RD_OUT: cyc=stb=1, we=0, adr=OMEM_BASE_sel+4k. On ack capture wbm_dat_i into shadow[32k+31:32k]; after k=7 go DONE.
- GAP: one cycle, cyc=stb=0, then the pending transfer state.
- DONE: copy shadow to spike_out_o (success only), pulse done_o, go IDLE.
- start_i while busy_o=1: ignored, no queuing.
- Reset (any time): all outputs to reset values immediately, FSM to IDLE, mid-transfer bus released.
- Reset values: all wbm_* outputs 0, busy_o=0, done_o=0, err_o=0, spike_out_o=0, shadow=0.

## Timing
- Transfer phase: outputs registered; stb asserted cycle N; ack sampled at rising edges while stb=1; earliest ack in cycle N, so transfer is 1 cycle plus 1 GAP cycle.
- Zero-wait slave: start accepted at edge 0; 8 writes + GAP = 16 cycles, calc + GAP = 2, 8 reads with 7 GAPs = 15, DONE 1; done_o high in cycle 34 after start edge.
- Address/data/we stable whole time stb=1.
- busy_o rises the cycle after start accepted, falls with done_o's falling edge (same edge FSM enters IDLE).

## Configuration
- SNN_WBM_TIMEOUT_EN defined: per-transfer counter counts cycles with stb=1 and no ack. On reaching ACK_TIMEOUT, drop cyc/stb, go DONE with err_o=1. spike_out_o is not updated.
- Undefined: no counter; FSM waits indefinitely for ack; err_o tied 0.

## Test plan
- Zero-wait slave, core_sel=0, spike_vec={8{32'hA5A5_0000+k}} per word: 8 writes to 0x80000000..0x8000001C with matching data, write to 0x80030000, reads 0x80040000..1C; slave returns 32'h1000_000k; spike_out_o matches; done_o in cycle 34.
- core_sel=1, slave with 3 wait cycles per ack: addresses use 0x80010000/0x80030004/0x80050000; stb held with stable adr; done_o at cycle 34+17×3=85.
- start_i repeated during busy: ignored; exactly 17 transfers observed.
- Reset asserted mid-RD_OUT (k=4): cyc/stb drop asynchronously, busy_o=0, spike_out_o=0; a new start runs cleanly.
- With SNN_WBM_TIMEOUT_EN, slave never acks first write: stb high 255 cycles, then cyc=0, done_o=err_o=1, spike_out_o unchanged from prior run.
